// File: rtl/mem_arbiter.sv
// Shares one single-ported 32-bit memory between the instruction-fetch and
// data ports. Each access walks IDLE->GRANT->ACCESS->RESP->DONE. Data wins
// arbitration. A streak counter bounds how long a pending fetch can starve.
module mem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ACCESS, S_RESP, S_DONE} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t            state, state_nx;
  logic              own_if;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [3:0]        lat_be;
  logic [31:0]       lat_wdata;
  logic              kill;
  logic [3:0]        d_streak;
  logic              if_elig, at_max, grant_if, grant_d;

  // Arbitration: a flushing fetch is not eligible; a saturated data streak
  // hands the slot to an eligible fetch. The two grants are mutually exclusive.
  always_comb begin
    if_elig  = if_req & ~if_flush;
    at_max   = (d_streak == STREAK_MAX);
    grant_if = if_elig & (~d_req | at_max);
    grant_d  = d_req & ~(if_elig & at_max);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state: only IDLE waits on a request. Every other state advances each cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (grant_if || grant_d) state_nx = S_GRANT;
      S_GRANT:  state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_RESP;
      S_RESP:   state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Latch the winning request. Later input changes are ignored until IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_if    <= 1'b0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
    end else if (state == S_IDLE && (grant_if || grant_d)) begin
      own_if    <= grant_if;
      lat_addr  <= grant_if ? if_addr : d_addr;
      lat_we    <= grant_d & d_we;
      lat_be    <= grant_if ? 4'hF : d_be;
      lat_wdata <= grant_if ? 32'h0 : d_wdata;
    end
  end

  // Data streak: counts data grants taken while a fetch waits.
  // It clears whenever a fetch is granted or no fetch is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_streak <= '0;
    end else if (state == S_IDLE) begin
      if (grant_if || !if_req)       d_streak <= '0;
      else if (grant_d && !at_max)   d_streak <= d_streak + 4'd1;
    end
  end

  // Memory drive: registered in GRANT, so m_en is high for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      m_en <= (state == S_GRANT);
      if (state == S_GRANT) begin
        m_we    <= lat_we;
        m_be    <= lat_be;
        m_addr  <= lat_addr;
        m_wdata <= lat_wdata;
      end else if (state == S_ACCESS) begin
        m_we    <= 1'b0;
      end
    end
  end

  // Kill flag: a PC redirect during a fetch's sequence discards its result.
  always_ff @(posedge clk) begin
    if (rst)                                   kill <= 1'b0;
    else if (state == S_IDLE)                  kill <= 1'b0;
    else if (state != S_DONE && own_if && if_flush) kill <= 1'b1;
  end

  // Response capture in RESP. The ready pulse is visible for the DONE cycle only.
  // A flush arriving in RESP itself must also suppress the fetch result.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
    end else if (state == S_RESP) begin
      if (own_if) begin
        if (!kill && !if_flush) begin
          if_rdata <= m_rdata;
          if_ready <= 1'b1;
        end
      end else begin
        d_ready <= 1'b1;
        if (!lat_we) d_rdata <= m_rdata;
      end
    end else if (state == S_DONE) begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
    end
  end

  // busy is registered from next state so it tracks "state != IDLE" exactly.
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. A behavioural registered memory sits on
// the m_* port. Expected read data is queued when a request is issued and
// popped when the matching *_ready pulse appears.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ready;
  logic [6:0]  if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_ready;
  logic [3:0]  d_be;
  logic [6:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        m_en, m_we, busy;
  logic [3:0]  m_be;
  logic [6:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  logic        mem_clr;
  logic [31:0] mem [128];
  logic [127:0] wvld;

  int ntot  = 0;
  int npass = 0;
  logic [31:0] dq[$];
  logic [31:0] iq[$];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(7), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
  );

  // Contents of a word that has never been written.
  function automatic logic [31:0] pat(input logic [6:0] a);
    if (a == 7'h05) return 32'hDEADBEEF;
    return {8'hC0, 1'b0, a, 8'h3C, 1'b0, ~a};
  endfunction

  // Single-ported memory: read data registered, byte-masked writes, not reset by rst.
  always @(posedge clk) begin : memb
    logic [31:0] cur;
    if (mem_clr) begin
      wvld <= '0;
    end else if (m_en) begin
      cur = wvld[m_addr] ? mem[m_addr] : pat(m_addr);
      if (m_we) begin
        for (int b = 0; b < 4; b++) if (m_be[b]) cur[b*8 +: 8] = m_wdata[b*8 +: 8];
        mem[m_addr]  <= cur;
        wvld[m_addr] <= 1'b1;
      end else begin
        m_rdata <= cur;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait up to maxc cycles for a ready pulse; lat = cycles waited, -1 on timeout.
  task automatic wait_rdy(input bit fetch, input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (fetch ? if_ready : d_ready) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic req_load(input logic [6:0] a);
    d_addr = a; d_we = 1'b0; d_be = 4'h0; d_req = 1'b1;
    dq.push_back(pat(a));
  endtask

  task automatic req_fetch(input logic [6:0] a);
    if_addr = a; if_req = 1'b1;
    iq.push_back(pat(a));
  endtask

  task automatic pop_d(input string tag);
    logic [31:0] e;
    e = (dq.size() > 0) ? dq.pop_front() : 32'hBAD0BAD0;
    chk(tag, d_rdata, e);
  endtask

  task automatic pop_i(input string tag);
    logic [31:0] e;
    e = (iq.size() > 0) ? iq.pop_front() : 32'hBAD0BAD0;
    chk(tag, if_rdata, e);
  endtask

  initial begin
    int lat, nd, prev;
    bit got_if;
    logic [31:0] st_exp;

    rst = 1'b1; mem_clr = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    // Reset state
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_m_en", {31'b0, m_en}, 32'd0);
    chk("rst_rdy",  {30'b0, if_ready, d_ready}, 32'd0);
    chk("rst_m_be", {28'b0, m_be}, 32'd0);
    chk("rst_m_addr", {25'b0, m_addr}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_streak", {28'b0, dut.d_streak}, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;

    // Load from 0x05, cycle by cycle.
    req_load(7'h05);
    tick(); chk("ld_busy1", {31'b0, busy}, 32'd1);
            chk("ld_m_en1", {31'b0, m_en}, 32'd0);
    tick(); chk("ld_m_en2", {31'b0, m_en}, 32'd1);
            chk("ld_m_addr", {25'b0, m_addr}, 32'h05);
            chk("ld_m_we", {31'b0, m_we}, 32'd0);
    tick(); chk("ld_rdy3", {31'b0, d_ready}, 32'd0);
    tick(); chk("ld_rdy4", {31'b0, d_ready}, 32'd1);
            pop_d("ld_data");
            chk("ld_if_rdata", if_rdata, 32'd0);
            d_req = 1'b0;
    tick(); chk("ld_rdy5", {31'b0, d_ready}, 32'd0);
            chk("ld_busy5", {31'b0, busy}, 32'd0);

    // Partial store to 0x10, then read it back.
    d_addr = 7'h10; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h12345678; d_req = 1'b1;
    tick(); tick();
    chk("st_m_en",  {31'b0, m_en}, 32'd1);
    chk("st_m_we",  {31'b0, m_we}, 32'd1);
    chk("st_m_be",  {28'b0, m_be}, 32'h3);
    chk("st_m_addr", {25'b0, m_addr}, 32'h10);
    chk("st_m_wdata", m_wdata, 32'h12345678);
    tick(); tick();
    chk("st_rdy", {31'b0, d_ready}, 32'd1);
    chk("st_d_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    st_exp = pat(7'h10);
    st_exp[15:0] = 16'h5678;
    d_addr = 7'h10; d_we = 1'b0; d_req = 1'b1;
    dq.push_back(st_exp);
    wait_rdy(1'b0, 10, lat);
    chk("rb_lat", 32'(lat), 32'd4);
    pop_d("rb_data");
    d_req = 1'b0;
    tick();

    // Streak limit: both ports request continuously.
    req_fetch(7'h20);
    req_load(7'h01);
    nd = 0; got_if = 1'b0; prev = -1;
    for (int i = 1; i <= 60 && !got_if; i++) begin
      tick();
      if (d_ready) begin
        nd++;
        pop_d("sk_d_data");
        if (prev >= 0) chk("sk_gap", 32'(i - prev), 32'd5);
        prev = i;
        dq.push_back(pat(7'h01));
      end
      if (if_ready) begin
        got_if = 1'b1;
        pop_i("sk_if_data");
      end
    end
    chk("sk_got_if", {31'b0, got_if}, 32'd1);
    chk("sk_ndata", 32'(nd), 32'd4);
    chk("sk_streak", {28'b0, dut.d_streak}, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    dq.delete();
    tick();

    // Flush during ACCESS discards the fetch.
    req_fetch(7'h21);
    wait_rdy(1'b1, 10, lat);
    chk("f0_lat", 32'(lat), 32'd4);
    pop_i("f0_data");
    if_req = 1'b0;
    tick();
    if_addr = 7'h22; if_req = 1'b1;
    tick(); tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick(); if_flush = 1'b0;
    chk("fl_rdy3", {31'b0, if_ready}, 32'd0);
    tick();
    chk("fl_rdy4", {31'b0, if_ready}, 32'd0);
    chk("fl_busy4", {31'b0, busy}, 32'd1);
    tick();
    chk("fl_busy5", {31'b0, busy}, 32'd0);
    chk("fl_rdy5", {31'b0, if_ready}, 32'd0);
    chk("fl_keep", if_rdata, pat(7'h21));
    req_fetch(7'h23);
    wait_rdy(1'b1, 10, lat);
    chk("f1_lat", 32'(lat), 32'd4);
    pop_i("f1_data");
    if_req = 1'b0;
    tick();

    // Reset during RESP of a load aborts it.
    d_addr = 7'h30; d_we = 1'b0; d_req = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; d_req = 1'b0;
    tick(); rst = 1'b0;
    chk("rr_rdy", {31'b0, d_ready}, 32'd0);
    chk("rr_busy", {31'b0, busy}, 32'd0);
    chk("rr_m_en", {31'b0, m_en}, 32'd0);
    chk("rr_m_be", {28'b0, m_be}, 32'd0);
    chk("rr_m_addr", {25'b0, m_addr}, 32'd0);
    chk("rr_d_rdata", d_rdata, 32'd0);
    chk("rr_if_rdata", if_rdata, 32'd0);
    tick();
    chk("rr_rdy_after", {31'b0, d_ready}, 32'd0);
    req_load(7'h31);
    wait_rdy(1'b0, 10, lat);
    chk("rr_new_lat", 32'(lat), 32'd4);
    pop_d("rr_new_data");
    d_req = 1'b0;
    tick();

    // Fetch with flush in the same IDLE cycle is not granted.
    if_flush = 1'b1;
    req_fetch(7'h24);
    tick();
    chk("sf_busy1", {31'b0, busy}, 32'd0);
    if_flush = 1'b0;
    tick();
    chk("sf_busy2", {31'b0, busy}, 32'd1);
    wait_rdy(1'b1, 10, lat);
    chk("sf_lat", 32'(lat), 32'd3);
    pop_i("sf_data");
    if_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
